// File: rtl/image_stream_source.sv
// Raster-order pixel source: reads a frame from a synchronous-read RAM and streams
// packed pixels with a clk_en qualifier, with optional zero-pixel flush beats at the end.
module image_stream_source #(
    parameter int D_WIDTH      = 8,
    parameter int D_CHANNELS   = 3,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int FLUSH_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stall,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd_en,
    input  logic [D_CHANNELS*D_WIDTH-1:0] mem_rd_data,
    output logic [D_CHANNELS*D_WIDTH-1:0] input_data,
    output logic                          clk_en,
    output logic                          busy,
    output logic                          done
);

    localparam int                    PW         = D_CHANNELS * D_WIDTH;
    localparam int                    N          = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(N - 1);
    localparam bit                    HAS_FLUSH  = (FLUSH_CYCLES > 0);
    localparam int                    FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0]         FLUSH_LAST = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FLUSH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd_valid;
    logic                  r_pix_vld;
    logic [PW-1:0]         r_pix;
    logic [FW-1:0]         r_flush_cnt;
    logic                  r_done;
    logic                  w_issue;
    logic                  w_flush_beat;
    logic                  w_end;

    always_comb begin
        w_issue      = (r_state == S_FETCH) && !stall;
        w_flush_beat = (r_state == S_FLUSH) && !stall;
        w_next       = r_state;
        w_end        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_issue && (r_addr == ADDR_LAST)) w_next = S_WAIT;
            end
            S_WAIT: begin
                // Last pixel is on the output when nothing is left in the read pipe.
                if (r_pix_vld && !r_rd_valid) begin
                    if (HAS_FLUSH) begin
                        w_next = S_FLUSH;
                    end else begin
                        w_next = S_IDLE;
                        w_end  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (w_flush_beat && (r_flush_cnt == FLUSH_LAST)) begin
                    w_next = S_IDLE;
                    w_end  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state != S_FLUSH) begin
                r_flush_cnt <= '0;
            end else if (w_flush_beat) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // RAM returns data one cycle after the read; register it once more for the output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_pix_vld  <= 1'b0;
            r_pix      <= '0;
        end else begin
            r_rd_valid <= w_issue;
            r_pix_vld  <= r_rd_valid;
            if (r_rd_valid) r_pix <= mem_rd_data;
        end
    end

    assign mem_addr   = r_addr;
    assign mem_rd_en  = w_issue;
    assign clk_en     = r_pix_vld | w_flush_beat;
    assign input_data = (r_state == S_FLUSH) ? '0 : r_pix;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source: one instance without flush, one with four
// flush beats, both fed the same control inputs from behavioural frame RAMs.
module tb_image_stream_source;

    localparam int N  = 2048;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stall;

    logic [10:0]   addr0, addr1;
    logic          rd_en0, rd_en1;
    logic [PW-1:0] rdata0, rdata1;
    logic [PW-1:0] data0, data1;
    logic          clk_en0, clk_en1;
    logic          busy0, busy1;
    logic          done0, done1;

    int tests_run = 0;
    int tests_failed = 0;

    int n_rd, rd_first, rd_last, addr_err, addr_at102;
    int n_beat, beat_first, beat_last, data_err;
    int n_done, done_last, n_busy, busy_first, busy_last, nz_after_rst;
    bit beat_at [0:4299];
    bit rd_at   [0:4299];

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] word(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, ~b, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (rd_en0) rdata0 <= word(int'(addr0));
        if (rd_en1) rdata1 <= word(int'(addr1));
    end

    image_stream_source #(.FLUSH_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .mem_addr(addr0), .mem_rd_en(rd_en0), .mem_rd_data(rdata0),
        .input_data(data0), .clk_en(clk_en0), .busy(busy0), .done(done0)
    );

    image_stream_source #(.FLUSH_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .mem_addr(addr1), .mem_rd_en(rd_en1), .mem_rd_data(rdata1),
        .input_data(data1), .clk_en(clk_en1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one run; cycle 0 is the cycle in which start is first high.
    task automatic run(input int sel, input int s1, input int s2, input int st_lo,
                       input int st_hi, input int rst_c, input int ncyc);
        logic          o_rd, o_ce, o_busy, o_done;
        logic [10:0]   o_addr;
        logic [PW-1:0] o_data, expd;
        int            fl, pos;
        fl = sel ? 4 : 0;
        n_rd = 0; rd_first = -1; rd_last = -1; addr_err = 0; addr_at102 = -1;
        n_beat = 0; beat_first = -1; beat_last = -1; data_err = 0;
        n_done = 0; done_last = -1; n_busy = 0; busy_first = -1; busy_last = -1;
        nz_after_rst = 0;
        for (int i = 0; i < 4300; i++) begin
            beat_at[i] = 1'b0;
            rd_at[i]   = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == s1) || (c == s2);
            stall = (c >= st_lo) && (c <= st_hi);
            rst_n = !((rst_c >= 0) && (c >= rst_c) && (c < rst_c + 2));
            #1;
            o_rd   = sel ? rd_en1  : rd_en0;
            o_addr = sel ? addr1   : addr0;
            o_ce   = sel ? clk_en1 : clk_en0;
            o_data = sel ? data1   : data0;
            o_busy = sel ? busy1   : busy0;
            o_done = sel ? done1   : done0;
            beat_at[c] = o_ce;
            rd_at[c]   = o_rd;
            if (c == 102) addr_at102 = int'(o_addr);
            if (o_rd) begin
                if (int'(o_addr) != (n_rd % N)) addr_err++;
                n_rd++;
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (o_ce) begin
                pos  = n_beat % (N + fl);
                expd = (pos < N) ? word(pos) : '0;
                if (o_data !== expd) data_err++;
                n_beat++;
                if (beat_first < 0) beat_first = c;
                beat_last = c;
            end
            if (o_done) begin
                n_done++;
                done_last = c;
            end
            if (o_busy) begin
                n_busy++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if ((rst_c >= 0) && (c >= rst_c) &&
                (o_rd || (o_addr != 0) || (o_data != 0) || o_ce || o_busy || o_done))
                nz_after_rst++;
        end
        start = 1'b0;
        stall = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr",  addr0,   0);
        check("rst_rd_en", rd_en0,  0);
        check("rst_data",  data0,   0);
        check("rst_clken", clk_en0, 0);
        check("rst_busy",  busy0,   0);
        check("rst_done",  done0,   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, -1, -1, -1, -2, -1, 2100);
        check("plain_rd_cnt",     n_rd, 2048);
        check("plain_rd_first",   rd_first, 1);
        check("plain_rd_last",    rd_last, 2048);
        check("plain_addr_err",   addr_err, 0);
        check("plain_beats",      n_beat, 2048);
        check("plain_beat_first", beat_first, 3);
        check("plain_beat_last",  beat_last, 2050);
        check("plain_data_err",   data_err, 0);
        check("plain_done_cnt",   n_done, 1);
        check("plain_done_cyc",   done_last, 2051);
        check("plain_busy_cnt",   n_busy, 2050);
        check("plain_busy_first", busy_first, 1);
        check("plain_busy_last",  busy_last, 2050);

        run(0, -1, -1, 100, 104, -1, 2100);
        check("stall_addr_hold", addr_at102, 99);
        check("stall_addr_err",  addr_err, 0);
        check("stall_beats",     n_beat, 2048);
        check("stall_data_err",  data_err, 0);
        check("stall_beat_last", beat_last, 2055);
        check("stall_done_cnt",  n_done, 1);
        check("stall_done_cyc",  done_last, 2056);

        run(0, 10, 500, -1, -2, -1, 2100);
        check("restart_rd_cnt",   n_rd, 2048);
        check("restart_addr_err", addr_err, 0);
        check("restart_beats",    n_beat, 2048);
        check("restart_data_err", data_err, 0);
        check("restart_done_cnt", n_done, 1);
        check("restart_done_cyc", done_last, 2051);

        run(0, -1, -1, -1, -2, 700, 800);
        check("abort_nonzero",  nz_after_rst, 0);
        check("abort_done_cnt", n_done, 0);
        check("abort_data_err", data_err, 0);

        run(0, -1, -1, -1, -2, -1, 2100);
        check("after_rst_rd_first",   rd_first, 1);
        check("after_rst_addr_err",   addr_err, 0);
        check("after_rst_beat_first", beat_first, 3);
        check("after_rst_beats",      n_beat, 2048);
        check("after_rst_done_cyc",   done_last, 2051);

        run(1, -1, -1, -1, -2, -1, 2100);
        check("flush_beats",      n_beat, 2052);
        check("flush_beat_first", beat_first, 3);
        check("flush_beat_last",  beat_last, 2054);
        check("flush_data_err",   data_err, 0);
        check("flush_done_cnt",   n_done, 1);
        check("flush_done_cyc",   done_last, 2055);
        check("flush_busy_last",  busy_last, 2054);

        run(1, -1, -1, 2052, 2052, -1, 2100);
        check("fstall_beats",    n_beat, 2052);
        check("fstall_b2051",    beat_at[2051], 1);
        check("fstall_b2052",    beat_at[2052], 0);
        check("fstall_b2053",    beat_at[2053], 1);
        check("fstall_last",     beat_last, 2055);
        check("fstall_data_err", data_err, 0);
        check("fstall_done_cyc", done_last, 2056);

        run(0, 2051, -1, -1, -2, -1, 4200);
        check("chain_rd_2052",   rd_at[2052], 1);
        check("chain_addr_err",  addr_err, 0);
        check("chain_beats",     n_beat, 4096);
        check("chain_b2053",     beat_at[2053], 0);
        check("chain_b2054",     beat_at[2054], 1);
        check("chain_beat_last", beat_last, 4101);
        check("chain_data_err",  data_err, 0);
        check("chain_done_cnt",  n_done, 2);
        check("chain_done_cyc",  done_last, 4102);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
